alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface. Accepts one RISC-V RV32I ALU instruction at a time over
//  a valid/ready handshake and reads rs1/rs2 from the register file. Drives the ALU's op1, op2
//  and 5-bit ctrl inputs, captures the ALU result and writes it back to rd.

---
 rtl/alu_issue_pkg.sv | 22 ++
 rtl/alu_issue_decode.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared ALU control encodings, RV32I opcode/funct constants and issue FSM states.
package alu_issue_pkg;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3
  } alu_ctrl_e;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } issue_state_e;
endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode to ALU control, immediate select and legality.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output alu_ctrl_e             ctrl,
  output logic                  use_imm,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  legal
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  always_comb begin
    ctrl    = ALU_ADD;
    use_imm = 1'b0;
    legal   = 1'b0;
    if (opc == OPC_RTYPE) begin
      legal = (f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_SUB)) ||
              ((f3 == F3_AND || f3 == F3_OR) && f7 == F7_BASE);
      ctrl  = (f3 == F3_AND) ? ALU_AND : (f3 == F3_OR) ? ALU_OR :
              (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
    end else if (opc == OPC_ITYPE) begin
      use_imm = 1'b1;
      legal   = (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR);
      ctrl    = (f3 == F3_AND) ? ALU_AND : (f3 == F3_OR) ? ALU_OR : ALU_ADD;
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one RV32I ALU instruction at a time (IDLE/DECODE/EXEC/WB) and writes back rd.
// Optional ALU_ISSUE_PERF_EN adds retired_cnt/illegal_cnt counters.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  input  logic [DATA_WIDTH-1:0] rd_data2,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [4:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  done,
  output logic                  illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]           retired_cnt,
  output logic [15:0]           illegal_cnt
`endif
);
  issue_state_e          state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d, result_q, result_d;
  alu_ctrl_e             alu_ctrl_q, alu_ctrl_d;
  logic                  illegal_q, illegal_d;
  alu_ctrl_e             dec_ctrl;
  logic                  dec_use_imm, dec_legal;
  logic [DATA_WIDTH-1:0] dec_imm;
  alu_issue_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr   (instr_q),
    .ctrl    (dec_ctrl),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .legal   (dec_legal)
  );
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    alu_ctrl_d = alu_ctrl_q;
    result_d   = result_q;
    illegal_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = S_DECODE;
      end
      S_DECODE: if (dec_legal) begin
        alu_op1_d  = rd_data1;
        alu_op2_d  = dec_use_imm ? dec_imm : rd_data2;
        alu_ctrl_d = dec_ctrl;
        state_d    = S_EXEC;
      end else begin
        illegal_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_EXEC: begin
        result_d = alu_out;
        state_d  = S_WB;
      end
      S_WB: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_ctrl_q <= ALU_ADD;
      result_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      alu_ctrl_q <= alu_ctrl_d;
      result_q   <= result_d;
      illegal_q  <= illegal_d;
    end
  end
  assign instr_ready = state_q == S_IDLE;
  assign rd_addr1    = (state_q == S_DECODE) ? ADDR_WIDTH'(instr_q[19:15]) : '0;
  assign rd_addr2    = (state_q == S_DECODE) ? ADDR_WIDTH'(instr_q[24:20]) : '0;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign done        = state_q == S_WB;
  // x0 is hardwired zero, so a write to rd=0 retires without a regfile write
  assign wr_en       = done && (instr_q[11:7] != 5'd0);
  assign wr_addr     = done ? ADDR_WIDTH'(instr_q[11:7]) : '0;
  assign wr_data     = done ? result_q : '0;
  assign illegal     = illegal_q;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;
  always_comb begin
    retired_cnt_d = retired_cnt_q + {31'd0, done};
    illegal_cnt_d = illegal_cnt_q + {15'd0, illegal_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end
  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench; stimulus pushes expected retire/illegal events, monitor pops and compares.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [4:0]  alu_ctrl;
  logic        wr_en, done, illegal;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] retired_cnt;
  logic [15:0] illegal_cnt;
`endif
  logic [31:0] rf [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        ill;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  ctrl;
    int          cyc;
  } exp_t;
  exp_t sb [$];
  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .illegal(illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd_data1 = rf[rd_addr1];
  assign rd_data2 = rf[rd_addr2];
  assign alu_out = (alu_ctrl == 5'd0) ? alu_op1 + alu_op2 : (alu_ctrl == 5'd1) ? alu_op1 - alu_op2 :
                   (alu_ctrl == 5'd2) ? alu_op1 & alu_op2 : (alu_ctrl == 5'd3) ? alu_op1 | alu_op2 : '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic exp_t ok(input logic [4:0] rd, input logic [31:0] data, op1, op2,
                              input logic [4:0] ctrl);
    exp_t e;
    e.ill = 1'b0; e.we = rd != 5'd0; e.addr = rd; e.data = data;
    e.op1 = op1; e.op2 = op2; e.ctrl = ctrl; e.cyc = 0;
    return e;
  endfunction
  function automatic exp_t bad();
    exp_t e;
    e.ill = 1'b1; e.we = 1'b0; e.addr = '0; e.data = '0;
    e.op1 = '0; e.op2 = '0; e.ctrl = '0; e.cyc = 0;
    return e;
  endfunction
  task automatic issue(input logic [31:0] ins, input logic [31:0] v1, v2, input exp_t e,
                       input bit push, input bit hold);
    int w = 0;
    @(negedge clk);
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    rf[ins[24:20]] = v2;
    rf[ins[19:15]] = v1;
    instr = ins;
    instr_valid = 1'b1;
    e.cyc = cyc + (e.ill ? 2 : 3);
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 if (!hold) instr_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    chk("wr_en_without_done", {31'd0, wr_en & ~done}, 32'd0);
    if (done || illegal) begin
      if (sb.size() == 0) chk("unexpected_output", {30'd0, done, illegal}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("done", {31'd0, done}, {31'd0, ~e.ill});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("wr_en", {31'd0, wr_en}, {31'd0, e.we});
        if (!e.ill) begin
          chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
          chk("wr_data", wr_data, e.data);
          chk("alu_op1", alu_op1, e.op1);
          chk("alu_op2", alu_op2, e.op2);
          chk("alu_ctrl", {27'd0, alu_ctrl}, {27'd0, e.ctrl});
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_outputs", {wr_en, done, illegal, alu_ctrl}, 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    rst_n = 1'b1;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, ok(5'd3, 32'd12, 32'd5, 32'd7, 5'd0), 1, 0);
    issue(itype(12'hFFF, 5'd1, 3'b000, 5'd4), 32'd0, 32'hDEAD, ok(5'd4, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 5'd0), 1, 0);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd5), 32'd0, 32'd1, ok(5'd5, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd1), 1, 0);
    issue(itype(12'h0F0, 5'd1, 3'b110, 5'd6), 32'h00F, 32'd0, ok(5'd6, 32'h0FF, 32'h00F, 32'h0F0, 5'd3), 1, 0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 32'hF0F0, 32'hFF00, ok(5'd7, 32'hF000, 32'hF0F0, 32'hFF00, 5'd2), 1, 0);
    issue(itype(12'h800, 5'd1, 3'b111, 5'd8), 32'hFFFFFFFF, 32'd0, ok(5'd8, 32'hFFFFF800, 32'hFFFFFFFF, 32'hFFFFF800, 5'd2), 1, 0);
    issue(rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd9), 32'd3, 32'd4, bad(), 1, 0);
    repeat (3) @(negedge clk);
    chk("ready_after_illegal", {31'd0, instr_ready}, 32'd1);
    issue({12'd0, 5'd1, 3'b010, 5'd10, 7'b0000011}, 32'd1, 32'd0, bad(), 1, 0);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'b111, 5'd11), 32'd1, 32'd2, bad(), 1, 0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7, ok(5'd0, 32'd12, 32'd5, 32'd7, 5'd0), 1, 0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), 32'h1, 32'h2, ok(5'd12, 32'h3, 32'h1, 32'h2, 5'd3), 1, 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("ready_busy_held_valid", {31'd0, instr_ready}, 32'd0);
    end
    instr_valid = 1'b0;
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd13), 32'd1, 32'd1, ok(5'd13, 32'd2, 32'd1, 32'd1, 5'd0), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_wr_en_done", {30'd0, wr_en, done}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("retired_cnt_reset", retired_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 32'd10, 32'd20, ok(5'd14, 32'd30, 32'd10, 32'd20, 5'd0), 1, 0);
    issue(itype(12'h001, 5'd1, 3'b000, 5'd15), 32'hFFFFFFFF, 32'd0, ok(5'd15, 32'd0, 32'hFFFFFFFF, 32'd1, 5'd0), 1, 0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd16), 32'hAA, 32'h0F, ok(5'd16, 32'h0A, 32'hAA, 32'h0F, 5'd2), 1, 0);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
`ifdef ALU_ISSUE_PERF_EN
    chk("retired_cnt", retired_cnt, 32'd3);
    chk("illegal_cnt", {16'd0, illegal_cnt}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
